// File: rtl/exe_muldiv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// exe_muldiv_ctrl_pkg
// Shared constants and types for the iterative RV32M multiply/divide unit:
// operand widths, R-type/M-extension decode constants, funct3 op codes,
// FSM state encoding and a small conditional-negate helper.
// ----------------------------------------------------------------------------
package exe_muldiv_ctrl_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int RDATA_WIDTH = 32;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M      = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_muldiv_ctrl_iter_step.sv
// ----------------------------------------------------------------------------
// muldiv_iter_step
// Combinational single radix-2 step on the 64-bit product/remainder register.
//   Multiply: conditional add of the multiplicand into the upper half, then
//             shift right by one (carry enters bit 63).
//   Divide:   shift left by one, trial-subtract the divisor from the upper
//             half and restore on borrow; the quotient bit enters bit 0.
// Ports:
//   is_div   in  1   select divide step (present only with MULDIV_DIV_EN)
//   acc      in  64  current product/remainder register
//   operand  in  32  multiplicand or divisor magnitude
//   acc_next out 64  register value after one step
// Build option: MULDIV_DIV_EN enables the divide step.
// ----------------------------------------------------------------------------
module muldiv_iter_step (
`ifdef MULDIV_DIV_EN
    input  logic        is_div,
`endif
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] mul_sum;
`ifdef MULDIV_DIV_EN
    logic        div_ge;
    logic [31:0] div_diff;
`endif

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        acc_next = {mul_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
        // The shifted partial remainder is 33 bits wide; when it is >= the
        // divisor the true difference fits in 32 bits, so a 32-bit subtract
        // of the low bits gives the exact result.
        div_ge   = acc[63:31] >= {1'b0, operand};
        div_diff = acc[62:31] - operand;
        if (is_div) begin
            acc_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        end
`endif
    end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// exe_muldiv_ctrl
// Iterative RV32M multiply/divide unit for the execute stage. An accepted
// instruction takes 32 single-bit steps and presents its result as a
// one-cycle valid pulse 33 cycles after acceptance. Division by zero and
// signed overflow finish in one cycle.
// Ports:
//   clk_i        in  1   clock
//   rst_i        in  1   synchronous active-high reset
//   start_i      in  1   decode presents an instruction this cycle
//   inst_i       in  32  instruction word
//   op1_i/op2_i  in  32  rs1/rs2 operand values
//   flush_i      in  1   abort any operation in progress
//   busy_o       out 1   stall request
//   valid_o      out 1   result valid pulse
//   reg_wdata_o  out 32  result (zero when valid_o is low)
//   reg_we_o     out 1   register file write enable (= valid_o)
// Build option: MULDIV_DIV_EN enables DIV/DIVU/REM/REMU; without it only
// the multiply group is accepted.
// ----------------------------------------------------------------------------
module exe_muldiv_ctrl
    import exe_muldiv_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [RDATA_WIDTH-1:0] inst_i,
    input  logic [DATA_WIDTH-1:0]  op1_i,
    input  logic [DATA_WIDTH-1:0]  op2_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o,
    output logic                   reg_we_o
);

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [63:0] acc_reg, acc_next;
    logic [31:0] operand_reg, operand_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic        neg_reg, neg_next;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        unused_inst;

    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign funct7      = inst_i[31:25];
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

    logic op_ok;
`ifdef MULDIV_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~funct3[2];
`endif

    logic accept;
    assign accept = start_i && !rst_i && !flush_i && (state_reg == ST_IDLE) &&
                    (opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_M) && op_ok;

    // Operand magnitudes and result sign. MUL returns the low word, which is
    // sign-agnostic, so it runs unsigned. A remainder takes the dividend sign.
    logic        op1_neg, op2_neg, neg_result;
    logic [31:0] mag1, mag2;

    always_comb begin
        op1_neg    = op1_i[31] && (funct3 inside {INST_MULH, INST_MULHSU, INST_DIV, INST_REM});
        op2_neg    = op2_i[31] && (funct3 inside {INST_MULH, INST_DIV, INST_REM});
        mag1       = negate_if(op1_neg, op1_i);
        mag2       = negate_if(op2_neg, op2_i);
        neg_result = (funct3 == INST_REM) ? op1_neg : (op1_neg ^ op2_neg);
    end

`ifdef MULDIV_DIV_EN
    logic div_zero, div_ovf;
    assign div_zero = funct3[2] && (op2_i == 32'h0);
    assign div_ovf  = ((funct3 == INST_DIV) || (funct3 == INST_REM)) &&
                      (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
`endif

    logic [63:0] step_acc;

    muldiv_iter_step u_step (
`ifdef MULDIV_DIV_EN
        .is_div   (funct3_reg[2]),
`endif
        .acc      (acc_reg),
        .operand  (operand_reg),
        .acc_next (step_acc)
    );

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        acc_next     = acc_reg;
        operand_next = operand_reg;
        funct3_next  = funct3_reg;
        neg_next     = neg_reg;
        busy_o       = 1'b0;
        valid_o      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    busy_o       = 1'b1;
                    funct3_next  = funct3;
                    operand_next = mag2;
                    acc_next     = {32'h0, mag1};
                    neg_next     = neg_result;
                    count_next   = 5'd0;
                    state_next   = ST_CALC;
`ifdef MULDIV_DIV_EN
                    // Special cases preload the final quotient (low half)
                    // and remainder (high half) and skip the iteration.
                    if (div_zero) begin
                        acc_next   = {op1_i, 32'hFFFF_FFFF};
                        neg_next   = 1'b0;
                        state_next = ST_DONE;
                    end else if (div_ovf) begin
                        acc_next   = {32'h0, 32'h8000_0000};
                        neg_next   = 1'b0;
                        state_next = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                busy_o     = 1'b1;
                acc_next   = step_acc;
                count_next = count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_o    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            state_next = ST_IDLE;
            count_next = 5'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            count_reg   <= 5'd0;
            acc_reg     <= 64'h0;
            operand_reg <= 32'h0;
            funct3_reg  <= 3'b000;
            neg_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            acc_reg     <= acc_next;
            operand_reg <= operand_next;
            funct3_reg  <= funct3_next;
            neg_reg     <= neg_next;
        end
    end

    // Sign fix-up and word selection.
    logic [63:0] prod_fix;
    logic [31:0] result;

    always_comb begin
        prod_fix = neg_reg ? (~acc_reg + 64'd1) : acc_reg;
        case (funct3_reg)
            INST_MUL:                           result = prod_fix[31:0];
            INST_MULH, INST_MULHSU, INST_MULHU: result = prod_fix[63:32];
            INST_DIV, INST_DIVU:                result = negate_if(neg_reg, acc_reg[31:0]);
            INST_REM, INST_REMU:                result = negate_if(neg_reg, acc_reg[63:32]);
            default:                            result = 32'h0;
        endcase
    end

    assign reg_we_o    = valid_o;
    assign reg_wdata_o = valid_o ? result : '0;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exe_muldiv_ctrl
// Directed and randomized checks of exe_muldiv_ctrl against an arithmetic
// reference model. Build option MULDIV_DIV_EN selects whether divide ops are
// expected to execute or to be ignored.
// ----------------------------------------------------------------------------
module tb_exe_muldiv_ctrl;

    localparam logic [6:0] OPC_RM = 7'b0110011;
    localparam logic [6:0] F7_M   = 7'b0000001;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] wdata;
    logic        we;

    int checks = 0;
    int errors = 0;

    exe_muldiv_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .inst_i      (inst),
        .op1_i       (op1),
        .op2_i       (op2),
        .flush_i     (flush),
        .busy_o      (busy),
        .valid_o     (valid),
        .reg_wdata_o (wdata),
        .reg_we_o    (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [6:0] opc);
        logic [31:0] r;
        r        = $urandom;
        r[31:25] = f7;
        r[14:12] = f3;
        r[6:0]   = opc;
        return r;
    endfunction

    // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        int              sa32, sb32;
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa32 = a;
        sb32 = b;
        sa   = sa32;
        sb   = sb32;
        ua   = {32'h0, a};
        ub   = {32'h0, b};
        r    = 32'h0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = sa32 / sb32;
            end
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = sa32 % sb32;
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 32'h0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r = 32'h0;
            1: r = 32'hFFFF_FFFF;
            2: r = 32'h8000_0000;
            3: r = 32'h7FFF_FFFF;
            4: r = {28'h0, r[3:0]};
            default: ;
        endcase
        return r;
    endfunction

    // Issue one accepted op and check busy profile, latency, result and pulse width.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        logic [31:0] got;
        int          exp_lat;
        int          lat;
        logic        busy_ok;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        @(negedge clk);
        start = 1'b1;
        inst  = mk_inst(f3, F7_M, OPC_RM);
        op1   = a;
        op2   = b;
        #1;
        check1("busy_accept", busy, 1'b1);
        busy_ok = 1'b1;
        lat     = 0;
        got     = 32'h0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            inst  = $urandom;
            op1   = $urandom;
            op2   = $urandom;
            #1;
            if (valid === 1'b1) begin
                lat = c;
                got = wdata;
                check1("we_eq_valid", we, 1'b1);
                check1("busy_done", busy, 1'b0);
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check32("latency", 32'(lat), 32'(exp_lat));
        check32("result", got, exp_res);
        check1("busy_calc", busy_ok, 1'b1);
        @(negedge clk);
        #1;
        check1("valid_pulse", valid, 1'b0);
        check32("wdata_idle", wdata, 32'h0);
        $display("op f3=%0d a=%h b=%h result=%h expected=%h latency=%0d", f3, a, b, got, exp_res, lat);
    endtask

    // Present an instruction that must not be accepted.
    task automatic run_ignored(input string tag, input logic [31:0] instr);
        logic seen;
        @(negedge clk);
        start = 1'b1;
        inst  = instr;
        op1   = $urandom;
        op2   = $urandom;
        #1;
        check1({tag, "_busy"}, busy, 1'b0);
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check1({tag, "_quiet"}, seen, 1'b0);
        $display("ignored %s inst=%h", tag, instr);
    endtask

    initial begin
        logic [31:0] a1, b1, a2, b2, got;
        logic [2:0]  f3;
        int          lat;
        int          first;
        logic        extra;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        inst  = 32'h0;
        op1   = 32'h0;
        op2   = 32'h0;

        // Reset overrides a valid start.
        @(negedge clk);
        start = 1'b1;
        inst  = mk_inst(3'd0, F7_M, OPC_RM);
        op1   = 32'd3;
        op2   = 32'd4;
        #1;
        check1("reset_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check1("reset_valid", valid, 1'b0);
        check1("reset_we", we, 1'b0);
        check32("reset_wdata", wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("post_reset_valid", valid, 1'b0);
        $display("reset done");

        // Directed multiply vectors.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);

        // Non-M instruction (ADD) and wrong opcode are ignored in every build.
        run_ignored("add", mk_inst(3'd0, 7'b0000000, OPC_RM));
        run_ignored("bad_opcode", mk_inst(3'd0, F7_M, 7'b0010011));

`ifdef MULDIV_DIV_EN
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd4, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd7, 32'hFFFF_FFF0, 32'd0);
`else
        run_ignored("divu", mk_inst(3'd5, F7_M, OPC_RM));
        run_ignored("div", mk_inst(3'd4, F7_M, OPC_RM));
        run_ignored("rem", mk_inst(3'd6, F7_M, OPC_RM));
`endif

        // Flush at cycle 10, restart at cycle 12, result expected at cycle 45.
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        @(negedge clk);
        start = 1'b1;
        inst  = mk_inst(3'd0, F7_M, OPC_RM);
        op1   = a1;
        op2   = b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 10);
            if (c == 12) begin
                start = 1'b1;
                inst  = mk_inst(3'd0, F7_M, OPC_RM);
                op1   = a2;
                op2   = b2;
            end
            #1;
            if (c == 11) begin
                check1("flush_busy", busy, 1'b0);
                check1("flush_valid", valid, 1'b0);
            end
            if (c == 12) check1("restart_busy", busy, 1'b1);
        end
        lat = 0;
        got = 32'h0;
        for (int c = 13; c <= 120; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (valid === 1'b1) begin
                lat = c;
                got = wdata;
                break;
            end
        end
        check32("flush_latency", 32'(lat), 32'd45);
        check32("flush_result", got, ref_result(3'd0, a2, b2));
        $display("flush restart result=%h at cycle %0d", got, lat);

        // Flush beats a simultaneous start.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        inst  = mk_inst(3'd3, F7_M, OPC_RM);
        #1;
        check1("flush_start_busy", busy, 1'b0);
        extra = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            #1;
            if (valid !== 1'b0) extra = 1'b1;
        end
        check1("flush_start_quiet", extra, 1'b0);
        $display("flush with start ignored");

        // start_i outside IDLE (in CALC and in DONE) is dropped.
        a1 = $urandom;
        b1 = $urandom;
        @(negedge clk);
        start = 1'b1;
        inst  = mk_inst(3'd3, F7_M, OPC_RM);
        op1   = a1;
        op2   = b1;
        first = 0;
        extra = 1'b0;
        got   = 32'h0;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            start = (c == 5) || (c == 33);
            inst  = mk_inst(3'd0, F7_M, OPC_RM);
            op1   = $urandom;
            op2   = $urandom;
            #1;
            if (c == 33) check1("done_start_busy", busy, 1'b0);
            if (valid === 1'b1) begin
                if (first == 0) begin
                    first = c;
                    got   = wdata;
                end else begin
                    extra = 1'b1;
                end
            end
        end
        start = 1'b0;
        check32("busy_start_latency", 32'(first), 32'd33);
        check32("busy_start_result", got, ref_result(3'd3, a1, b1));
        check1("busy_start_no_queue", extra, 1'b0);
        $display("start while busy dropped result=%h", got);

        // Reset mid-CALC abandons the op.
        @(negedge clk);
        start = 1'b1;
        inst  = mk_inst(3'd0, F7_M, OPC_RM);
        op1   = 32'd9;
        op2   = 32'd9;
        extra = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            rst   = (c == 5);
            start = (c == 5);
            #1;
            if (c == 6) begin
                check1("midreset_busy", busy, 1'b0);
                check32("midreset_wdata", wdata, 32'h0);
            end
            if (c >= 6 && valid !== 1'b0) extra = 1'b1;
        end
        start = 1'b0;
        check1("midreset_quiet", extra, 1'b0);
        $display("reset mid calc abandoned");

        // Randomized ops against the reference model.
        for (int i = 0; i < 24; i++) begin
`ifdef MULDIV_DIV_EN
            f3 = 3'($urandom_range(0, 7));
`else
            f3 = 3'($urandom_range(0, 3));
`endif
            run_op(f3, pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_muldiv_ctrl.md
EXE_MULDIV_CTRL -- requirements
Module: exe_muldiv_ctrl

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  synchronous, active-high reset.
REQ-003 start_i  in  1  decode presents an instruction to the exe stage this cycle.
REQ-004 inst_i  in  RDATA_WIDTH  instruction word; opcode [6:0], funct3 [14:12], funct7 [31:25].
REQ-005 op1_i, op2_i  in  DATA_WIDTH  rs1 / rs2 operand values.
REQ-006 flush_i  in  1  pipeline flush; aborts any operation in progress.
REQ-007 busy_o  out  1  stall request to the pipeline.
REQ-008 valid_o  out  1  result valid, one-cycle pulse.
REQ-009 reg_wdata_o  out  RDATA_WIDTH  result to the register file.
REQ-010 reg_we_o  out  1  write enable; equals valid_o.

Function
REQ-011 Accepted op (SHALL): start_i=1, state IDLE, opcode=INST_TYPE_R_M, funct7=7'b0000001; all other instructions are ignored.
REQ-012 funct3 encoding (SHALL): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-013 FSM states (SHALL): IDLE, CALC, DONE.
REQ-014 Transitions (SHALL): IDLE->CALC on accept; CALC->DONE after counter reaches 31; DONE->IDLE unconditionally.
REQ-015 Operand latching (SHALL): on accept, capture operand magnitudes, result-sign flags and funct3; inputs are don't-care afterwards.
REQ-016 CALC (SHALL): one radix-2 step per cycle, 32 cycles; shift-add for multiply, restoring subtract for divide; 64-bit product/remainder register.
REQ-017 Sign handling (SHALL): negate the final result per RISC-V rules; MULH/MULHSU/MULHU return bits [63:32], MUL returns bits [31:0].
REQ-018 Latency (SHALL): accept in cycle 0; valid_o high in cycle 33 for exactly one cycle.
REQ-019 Divide by zero (SHALL): IDLE->DONE directly, valid_o in cycle 1; quotient 32'hFFFFFFFF, remainder = op1_i.
REQ-020 Signed overflow, 32'h80000000 / 32'hFFFFFFFF (SHALL): IDLE->DONE directly; DIV result 32'h80000000, REM result 0.
REQ-021 busy_o (SHALL): combinational; = (IDLE and accept) or CALC; low in DONE so the pipeline advances with the result.
REQ-022 start_i outside IDLE (SHALL): ignored; no queuing.
REQ-023 flush_i=1 in any state (SHALL): next state IDLE, valid_o=0 next cycle; flush beats a simultaneous start_i.
REQ-024 Idle outputs (SHALL): reg_wdata_o=ZERO whenever valid_o=0.

Reset
REQ-025 rst_i=1 at a clock edge (SHALL): state IDLE, counter 0, internal registers 0, busy_o=0, valid_o=0, reg_we_o=0, reg_wdata_o=0; rst_i overrides flush_i and start_i.
REQ-026 Reset asserted mid-CALC (SHALL): abandon the operation; no valid_o pulse follows.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined (SHALL): all eight funct3 ops supported.
REQ-028 MULDIV_DIV_EN undefined (SHALL): only funct3[2]=0 is accepted; DIV/DIVU/REM/REMU are ignored (busy_o stays 0, no valid_o); divide datapath and special-case logic are removed.

Structure
REQ-029 Shared constants in defines.v (SHALL): INST_MUL..INST_REMU funct3 codes and FUNCT7_M=7'b0000001.
REQ-030 Sub-module muldiv_iter_step (SHALL): combinational single-step add/subtract-shift, instantiated once; FSM, counter and sign fix-up stay in exe_muldiv_ctrl.

Verification
REQ-031 MUL 7 x -3 -> valid_o at cycle 33, reg_wdata_o=32'hFFFFFFEB, busy_o high cycles 0-32.
REQ-032 MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE; MULH same operands -> 0.
REQ-033 DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14.
REQ-034 DIV 5/0 -> valid_o cycle 1, 32'hFFFFFFFF; REM 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000.
REQ-035 flush_i at cycle 10 of a MUL, then new start_i at cycle 12 -> no valid_o for the first op; second op result at cycle 45.
REQ-036 Without MULDIV_DIV_EN: start DIVU -> busy_o=0, no valid_o; ADD instruction with start_i -> ignored in both builds.
